// File: rtl/instr_fetch_unit.sv
// Purpose : instruction fetch front end; issues word fetches, buffers returned words, and hands them to decode.
// Latency : a memory response in cycle T is visible on instr_* in cycle T+1; one request per cycle at best.
// Backpressure: credit based; a request issues only while buffer + live + drop in-flight words leave a free slot.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   imem_req_valid/ready/addr           fetch request channel (valid/ready)
//   imem_rsp_valid/data                 in-order response words, no backpressure
//   redirect_valid/pc                   single-cycle taken branch/jump with new target
//   instr_valid/ready                   decode-side handshake
//   instr_data/pc                       word at buffer head and its address
//   instr_op/funct3/funct7_5            pre-decoded fields of instr_data
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [6:0]  instr_op,
  output logic [2:0]  instr_funct3,
  output logic        instr_funct7_5
);

  // Counter width holds 0..DEPTH; occupancy sum gets headroom for three counters.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = CW + 2;

  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  // Fetch state
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;     // address belonging to the next live response
  logic [CW-1:0] live_cnt;   // requests whose words will be kept
  logic [CW-1:0] drop_cnt;   // requests whose words belong to a squashed path

  // Instruction buffer
  logic [31:0]   buf_data [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] buf_cnt;

  // Per-cycle events
  logic          req_fire;
  logic          pop;
  logic          push;
  logic          rsp_drop;
  logic [SW-1:0] occupancy;
  logic [31:0]   redirect_aligned;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Handshake events
  // ---------------------------------------------------------------------------
  assign instr_valid = (buf_cnt != '0);
  assign pop         = instr_valid && instr_ready;

  // A pop this cycle frees a slot before any word fetched now can come back
  // (responses are at least one cycle after acceptance), so it is credited
  // immediately. This is what lets a 2-deep buffer stream with no bubbles.
  assign occupancy = SW'(buf_cnt) + SW'(live_cnt) + SW'(drop_cnt) - SW'(pop);

  // rst_n gates the request so nothing is offered while held in reset; the
  // first cycle after release already presents RESET_PC.
  assign imem_req_valid = rst_n && !redirect_valid && (occupancy < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses in a redirect cycle are squashed whatever the drop count says;
  // the drop counter update below accounts for that word.
  assign push     = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign rsp_drop = imem_rsp_valid && !redirect_valid && (drop_cnt != '0);

  // ---------------------------------------------------------------------------
  // Fetch PC, live / drop accounting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_aligned;
      rsp_pc   <= redirect_aligned;
      live_cnt <= '0;
      // Everything still live becomes garbage; a response arriving right now
      // retires one of the outstanding words.
      drop_cnt <= drop_cnt + live_cnt - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;  // natural 32-bit wrap
      end
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
      end
      live_cnt <= live_cnt + CW'(req_fire) - CW'(push);
      drop_cnt <= drop_cnt - CW'(rsp_drop);
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      buf_cnt <= '0;
    end else if (redirect_valid) begin
      // Flush; a pop in this cycle still counts as delivered to decode.
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      buf_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: contents are only observed behind instr_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]   <= rsp_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-side outputs, held by the head entry until popped
  // ---------------------------------------------------------------------------
  assign instr_data     = buf_data[rd_ptr];
  assign instr_pc       = buf_pc[rd_ptr];
  assign instr_op       = instr_data[6:0];
  assign instr_funct3   = instr_data[14:12];
  assign instr_funct7_5 = instr_data[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : directed, scoreboard-checked bench for instr_fetch_unit.
// Latency : memory model answers one cycle after acceptance, in order.
// Backpressure: memory ready is governed by a request budget; decode ready is directed.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;

  // Main DUT (RESET_PC = 0)
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic [6:0]  instr_op;
  logic [2:0]  instr_funct3;
  logic        instr_funct7_5;

  // Wrap-around DUT (RESET_PC = FFFF_FFFC)
  logic        w_req_valid, w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_instr_valid, w_instr_ready;
  logic [31:0] w_instr_data, w_instr_pc;
  logic [6:0]  w_instr_op;
  logic [2:0]  w_instr_funct3;
  logic        w_instr_funct7_5;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_op(instr_op), .instr_funct3(instr_funct3), .instr_funct7_5(instr_funct7_5)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
    .instr_data(w_instr_data), .instr_pc(w_instr_pc),
    .instr_op(w_instr_op), .instr_funct3(w_instr_funct3), .instr_funct7_5(w_instr_funct7_5)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  int          n_checks   = 0;
  int          n_fail     = 0;
  int          req_budget = 0;
  int          acc_cnt    = 0;
  bit          mem_rsp_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0204) return 32'h4000_D0B3;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_raw(input logic [31:0] pc, input logic [31:0] d,
                          input logic [6:0] op, input logic [2:0] f3, input logic f7);
    exp_t e;
    e.pc = pc; e.data = d; e.op = op; e.f3 = f3; e.f7 = f7;
    exp_q.push_back(e);
  endtask

  task automatic push_exp(input logic [31:0] pc);
    logic [31:0] d;
    d = mem_word(pc);
    push_raw(pc, d, d[6:0], d[14:12], d[30]);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
      @(negedge clk); #4;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Memory model: drives at negedge+1, samples acceptance at negedge+3.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        mem_q.delete();
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
      end else begin
        imem_req_ready = (req_budget > 0);
        if (mem_rsp_en && mem_q.size() > 0) begin
          imem_rsp_data  = mem_word(mem_q.pop_front());
          imem_rsp_valid = 1'b1;
        end else begin
          imem_rsp_valid = 1'b0;
        end
      end
      #2;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        mem_q.push_back(imem_req_addr);
        req_budget--;
        acc_cnt++;
      end
    end
  end

  // Monitor: compares every instruction handed to decode against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc %h with empty scoreboard", instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc",       instr_pc,              e.pc);
          chk("instr_data",     instr_data,            e.data);
          chk("instr_op",       32'(instr_op),         32'(e.op));
          chk("instr_funct3",   32'(instr_funct3),     32'(e.f3));
          chk("instr_funct7_5", 32'(instr_funct7_5),   32'(e.f7));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    int  base;
    bit  found;

    rst_n            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    instr_ready      = 1'b0;
    w_req_ready      = 1'b1;
    w_rsp_valid      = 1'b0;
    w_rsp_data       = '0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_instr_ready    = 1'b0;

    repeat (2) @(negedge clk);
    #4;
    chk("rst_req_valid",      32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid",    32'(instr_valid),    32'd0);
    chk("rst_wrap_req_valid", 32'(w_req_valid),    32'd0);

    // Streaming: 0,4,8,... back to back, decode sees them 2 cycles later.
    @(negedge clk);
    rst_n = 1'b1; req_budget = 8; mem_rsp_en = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) push_exp(32'(4 * k));
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #4;
      if (k == 0) begin
        chk("wrap_first_valid", 32'(w_req_valid), 32'd1);
        chk("wrap_first_addr",  w_req_addr,       32'hFFFF_FFFC);
      end
      if (k == 1) begin
        chk("wrap_second_valid", 32'(w_req_valid), 32'd1);
        chk("wrap_second_addr",  w_req_addr,       32'h0000_0000);
      end
      if (k < 8) begin
        chk("b2b_req_valid", 32'(imem_req_valid), 32'd1);
        chk("b2b_req_addr",  imem_req_addr,       32'(4 * k));
      end
      chk("stream_instr_valid", 32'(instr_valid), (k >= 2) ? 32'd1 : 32'd0);
    end

    // Decode stalled: only two requests fit, head stays stable.
    @(negedge clk);
    instr_ready = 1'b0; req_budget = 10; base = acc_cnt;
    push_exp(32'd32); push_exp(32'd36); push_exp(32'd40);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #4;
      if (k >= 2) begin
        chk("stall_instr_valid", 32'(instr_valid), 32'd1);
        chk("stall_instr_pc",    instr_pc,         32'd32);
      end
    end
    chk("stall_accepts",   32'(acc_cnt - base),  32'd2);
    chk("stall_req_valid", 32'(imem_req_valid),  32'd0);

    // One pop buys exactly one request.
    @(negedge clk);
    instr_ready = 1'b1;
    #4;
    chk("pop_credit_valid", 32'(imem_req_valid), 32'd1);
    chk("pop_credit_addr",  imem_req_addr,       32'd40);
    @(negedge clk);
    instr_ready = 1'b0;
    repeat (5) @(negedge clk);
    #4;
    chk("pop_credit_accepts", 32'(acc_cnt - base), 32'd3);
    chk("refull_req_valid",   32'(imem_req_valid), 32'd0);

    // Two requests in flight, then redirect to 0x102.
    @(negedge clk);
    instr_ready = 1'b1; mem_rsp_en = 1'b0; req_budget = 2; base = acc_cnt;
    repeat (4) @(negedge clk);
    #4;
    chk("inflight_accepts", 32'(acc_cnt - base), 32'd2);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; req_budget = 3;
    #4;
    chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0; mem_rsp_en = 1'b1;
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (i > 0) @(negedge clk);
      #4;
      if (imem_req_valid) found = 1'b1;
    end
    chk("redir_req_seen",    32'(found),    32'd1);
    chk("redir_first_addr",  imem_req_addr, 32'h0000_0100);
    wait_drain("redir_drain", 40);
    repeat (3) @(negedge clk);

    // Redirect coinciding with a response and a pop.
    @(negedge clk);                       // s0
    req_budget = 6;
    push_exp(32'h10C); push_exp(32'h110); push_exp(32'h200);
    push_raw(32'h204, 32'h4000_D0B3, 7'h33, 3'b101, 1'b1);
    push_exp(32'h208);
    #4;
    chk("s0_req_addr", imem_req_addr, 32'h0000_010C);
    @(negedge clk);                       // s1
    @(negedge clk);                       // s2
    @(negedge clk);                       // s3
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #4;
    chk("coinc_req_valid",   32'(imem_req_valid), 32'd0);
    chk("coinc_pop_valid",   32'(instr_valid),    32'd1);
    chk("coinc_pop_pc",      instr_pc,            32'h0000_0110);
    @(negedge clk);                       // s4
    redirect_valid = 1'b0;
    #4;
    chk("coinc_flush",       32'(instr_valid),    32'd0);
    chk("coinc_next_valid",  32'(imem_req_valid), 32'd1);
    chk("coinc_next_addr",   imem_req_addr,       32'h0000_0200);
    wait_drain("coinc_drain", 40);
    repeat (2) @(negedge clk);

    // Reset in the middle of operation with a full buffer.
    @(negedge clk);
    instr_ready = 1'b0; req_budget = 4;
    repeat (4) @(negedge clk);
    #4;
    chk("prefill_valid", 32'(instr_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0; req_budget = 0;
    #4;
    chk("midrst_instr_valid", 32'(instr_valid),    32'd0);
    chk("midrst_req_valid",   32'(imem_req_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; req_budget = 1; instr_ready = 1'b1;
    push_exp(32'h0);
    #4;
    chk("rerelease_valid", 32'(imem_req_valid), 32'd1);
    chk("rerelease_addr",  imem_req_addr,       32'h0000_0000);
    wait_drain("rerelease_drain", 20);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter DEPTH, default 2: instruction buffer entries and maximum in-flight requests.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_ready  in  1  memory accepts request.
REQ-008 imem_req_addr  out  32  word-aligned fetch address.
REQ-009 imem_rsp_valid  in  1  response word valid; responses arrive in request order, at most one per cycle, at least 1 cycle after acceptance.
REQ-010 imem_rsp_data  in  32  instruction word.
REQ-011 redirect_valid  in  1  taken branch/jump (PCSrc from control), single-cycle pulse.
REQ-012 redirect_pc  in  32  redirect target.
REQ-013 instr_valid  out  1  instruction available to decode.
REQ-014 instr_ready  in  1  decode consumes instruction.
REQ-015 instr_data  out  32  instruction word at buffer head.
REQ-016 instr_pc  out  32  address of instr_data.
REQ-017 instr_op  out  7  instr_data[6:0].
REQ-018 instr_funct3  out  3  instr_data[14:12].
REQ-019 instr_funct7_5  out  1  instr_data[30].

Function
REQ-020 Request handshake: a transfer occurs on a rising edge where imem_req_valid and imem_req_ready are both 1; imem_req_addr SHALL stay stable while valid is high and not accepted.
REQ-021 The unit SHALL assert imem_req_valid only if redirect_valid=0 and (buffer count + live in-flight + drop in-flight) < DEPTH.
REQ-022 imem_req_addr SHALL equal fetch_pc; fetch_pc SHALL advance by 4 (mod 2^32, wrapping 32'hFFFF_FFFC to 0) per accepted request.
REQ-023 An accepted request SHALL increment the live counter; a response while drop counter = 0 SHALL decrement live and push {data, pc} into the buffer.
REQ-024 A response while drop counter > 0 SHALL be discarded and SHALL decrement drop.
REQ-025 The buffer SHALL be a FIFO of DEPTH entries, registered: a response in cycle T SHALL make instr_valid=1 in cycle T+1 at the earliest.
REQ-026 Pop occurs when instr_valid and instr_ready are both 1; simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-027 The credit rule (REQ-021) SHALL guarantee no push into a full buffer; no overflow handling is required beyond that.
REQ-028 instr_data, instr_pc and the decoded fields SHALL remain stable while instr_valid=1 and instr_ready=0.
REQ-029 On redirect_valid=1: fetch_pc SHALL load {redirect_pc[31:2], 2'b00}; the buffer SHALL flush (instr_valid=0 next cycle); live SHALL become 0; drop SHALL become drop + live - (1 if a response arrives that cycle).
REQ-030 A response arriving in the redirect cycle SHALL be discarded, regardless of the drop count.
REQ-031 A pop in the redirect cycle SHALL complete normally; a push in that cycle SHALL NOT occur.
REQ-032 With instr_valid=0, the outputs instr_data, instr_pc and the decoded fields are don't-care.

Reset
REQ-033 While rst_n=0: fetch_pc=RESET_PC, live=0, drop=0, buffer count=0, imem_req_valid=0, instr_valid=0.
REQ-034 Reset assertion mid-operation SHALL discard all in-flight and buffered state immediately.
REQ-035 Responses for requests issued before reset are not permitted; the memory is reset together with the unit.
REQ-036 In the first cycle after deassertion, imem_req_valid=1 with imem_req_addr=RESET_PC.

Verification
REQ-037 Reset release, ready=1, 1-cycle memory, instr_ready=1 -> addresses 0,4,8,... are issued back-to-back; instr_pc follows the same sequence with 2-cycle latency and no gaps.
REQ-038 instr_ready=0 with DEPTH=2 -> exactly 2 requests are accepted, then imem_req_valid=0; one pop -> exactly one new request.
REQ-039 Redirect to 32'h0000_0102 with 2 requests in flight -> both responses are dropped; next address 32'h0000_0100; the first instr_pc after the redirect is 0x100.
REQ-040 Redirect in the same cycle as a response and a pop -> the pop completes, the response is discarded, drop = live-1, and imem_req_valid=0 that cycle.
REQ-041 RESET_PC=32'hFFFF_FFFC -> second request address 32'h0000_0000.
REQ-042 instr_data=32'h4000_D0B3 -> instr_op=7'h33, instr_funct3=3'b101, instr_funct7_5=1.
